fifo_flex: RTL
==============

Name: fifo_flex

Overview:
Synchronous single-clock FIFO; successor to the fixed power-of-2 FIFO.
Supports any depth, not only powers of 2, and exposes an explicit fill level.
Almost-full/almost-empty thresholds are set at runtime, and the block adds a synchronous flush plus sticky overflow/underflow error flags.
Used as the general-purpose elastic buffer between valid/ready stream stages.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DATA_DEPTH, 12, number of entries (>=2, any integer)
Derived, not overridable: ADDR_WIDTH = $clog2(DATA_DEPTH); CNT_WIDTH = $clog2(DATA_DEPTH+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush_i  in  1  synchronous flush: empties FIFO on next edge
wr_valid_i  in  1  write request
wr_ready_o  out  1  write accepted when high; equals ~full_o
wr_data_i  in  DATA_WIDTH  write data
rd_valid_o  out  1  read data valid; equals ~empty_o
rd_ready_i  in  1  read accept
rd_data_o  out  DATA_WIDTH  head-of-FIFO data, first-word-fall-through
full_o  out  1  level == DATA_DEPTH
empty_o  out  1  level == 0
almost_full_o  out  1  level >= af_thresh_i
almost_empty_o  out  1  level <= ae_thresh_i
level_o  out  CNT_WIDTH  current entry count, 0..DATA_DEPTH
af_thresh_i  in  CNT_WIDTH  almost-full threshold, quasi-static
ae_thresh_i  in  CNT_WIDTH  almost-empty threshold, quasi-static
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: read attempted while empty
err_clr_i  in  1  clears overflow_o/underflow_o

Behaviour:
- Storage: DATA_DEPTH x DATA_WIDTH register array, not reset. Write pointer, read pointer (ADDR_WIDTH) and level (CNT_WIDTH) are registers.
- Pointers increment by 1 and wrap from DATA_DEPTH-1 to 0. This wrap is explicit, not natural binary rollover, because depth may be non-power-of-2.
- Write fire: wr_valid_i & ~full_o. Read fire: rd_valid_o & rd_ready_i.
- Level: +1 on write-only fire, -1 on read-only fire, unchanged when both or neither fire.
- Full and reading: wr_ready_o stays low that cycle (no write-through bypass). The write may fire the following cycle.
- Empty and writing: no read fire (no bypass). The data appears on rd_data_o with rd_valid_o=1 in the cycle after the write edge, giving 1-cycle write-to-read latency.
- rd_data_o = array[rd_ptr], combinational. Its value is don't-care while empty_o=1.
- All status outputs (full_o, empty_o, almost_*, level_o) are combinational from the level register and threshold inputs only. There is no combinational path from wr_valid_i or rd_ready_i to any output.
- Threshold edge cases:
  - af_thresh_i=0 gives almost_full_o constantly 1.
  - af_thresh_i>DATA_DEPTH gives almost_full_o constantly 0.
  - ae_thresh_i=0 makes almost_empty_o equal empty_o.
- flush_i=1 at an edge:
  - wr_ptr, rd_ptr and level go to 0.
  - Any concurrent write or read in that cycle is discarded and does not update the array pointers.
  - Error flags are unaffected.
- Error flags:
  - overflow_o sets on the edge where wr_valid_i & full_o & ~flush_i.
  - underflow_o sets on the edge where rd_ready_i & empty_o & ~flush_i.
  - err_clr_i=1 clears both flags. If set and clear coincide, set wins.
- Priority per edge: rst > flush_i > normal operation.
- Reset (rst=1 at an edge):
  - Pointers=0, level_o=0, empty_o=1, rd_valid_o=0, full_o=0, wr_ready_o=1, overflow_o=0, underflow_o=0.
  - almost_empty_o=1; almost_full_o per threshold rule.
  - Reset mid-burst discards all contents. A write presented during reset is not stored.

Test Plan:
- Reset, DATA_DEPTH=12: write 12 words 0x01..0x0C back-to-back -> full_o=1, level_o=12, wr_ready_o=0. One extra write attempt -> overflow_o=1, contents intact. Drain -> 0x01..0x0C in order, empty_o=1.
- Wrap-around at DATA_DEPTH=12: 30 cycles of continuous simultaneous write/read after prefill of 5 -> level_o stays 5, output sequence strictly ordered across multiple pointer wraps.
- Full with rd_ready_i=1 and wr_valid_i=1 -> cycle 1: read fires, write stalls (level 11). Cycle 2: write fires (level 12).
- Thresholds af_thresh_i=9, ae_thresh_i=2: fill 0->12 -> almost_empty_o high for level 0..2; almost_full_o rises exactly when level_o becomes 9.
- Prefill 7, assert flush_i with wr_valid_i=1 -> next cycle level_o=0, empty_o=1, written word absent. Then write 0xA5 -> rd_data_o=0xA5 one cycle later.
- Read while empty -> underflow_o=1 and sticky. err_clr_i pulse coinciding with a new underflow keeps the flag 1; a clean err_clr_i pulse -> 0. rst=1 mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fifo_flex.sv
//------------------------------------------------------------------------------
// Module   : fifo_flex
// Brief    : Single-clock FWFT FIFO of any depth with runtime almost-full/empty
//            thresholds, fill level, synchronous flush and sticky error flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_flex #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 12,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
   localparam int CNT_WIDTH  = $clog2(DATA_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [CNT_WIDTH-1:0]  level_o,
   input  logic [CNT_WIDTH-1:0]  af_thresh_i,
   input  logic [CNT_WIDTH-1:0]  ae_thresh_i,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  err_clr_i
);

   localparam logic [CNT_WIDTH-1:0]  C_DEPTH     = CNT_WIDTH'(DATA_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic full, empty, wr_fire, rd_fire, mem_we;

   // Depth need not be a power of two, so the wrap point is explicit.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == C_LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full    = (level_q == C_DEPTH);
      empty   = (level_q == '0);
      wr_fire = wr_valid_i & ~full  & ~flush_i;
      rd_fire = rd_ready_i & ~empty & ~flush_i;
      mem_we  = wr_fire & ~rst;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (wr_fire && !rd_fire)      level_d = level_q + 1'b1;
         else if (rd_fire && !wr_fire) level_d = level_q - 1'b1;
      end

      // A new error event outranks a simultaneous clear.
      overflow_d  = (overflow_q  & ~err_clr_i) | (wr_valid_i & full  & ~flush_i);
      underflow_d = (underflow_q & ~err_clr_i) | (rd_ready_i & empty & ~flush_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_comb begin
      rd_data_o      = mem_q[rd_ptr_q];
      full_o         = full;
      empty_o        = empty;
      wr_ready_o     = ~full;
      rd_valid_o     = ~empty;
      level_o        = level_q;
      almost_full_o  = (level_q >= af_thresh_i);
      almost_empty_o = (level_q <= ae_thresh_i);
      overflow_o     = overflow_q;
      underflow_o    = underflow_q;
   end

endmodule

`default_nettype wire
